foo_correction_mc: RTL
======================

Name: foo_correction_mc

Overview:
- Next-generation multi-channel pixel correction stage for the foo image path.
- Each beat carries P_CH_NUM pixels; each pixel gets pedestal-referenced gain and shift, selected per Bayer phase.
- Output is clamped and flows through a 3-stage pipeline with a valid/ready handshake and backpressure.
- Configuration is shadowed and takes effect only at start-of-frame, so a frame never mixes settings.

Parameters:
- P_CH_NUM, 4, pixels per beat; must be even.
- P_PIX_BIT, 12, pixel width, unsigned.
- P_GAIN_BIT, 10, gain width, unsigned Q2.8 (256 = 1.0).
- P_SFT_BIT, 3, width of the extra right-shift field.
- P_PED_BIT, 10, pedestal width; must be <= P_PIX_BIT.

Ports:
- i_CLK  in  1  clock
- i_RSTn  in  1  asynchronous active-low reset
- i_VALID  in  1  input beat valid
- o_READY  out  1  block can accept a beat
- i_SOF  in  1  beat is first of frame
- i_EOL  in  1  beat is last of line
- i_PIXELS  in  P_CH_NUM*P_PIX_BIT  input pixels; channel 0 in the LSBs
- o_VALID  out  1  output beat valid
- i_READY  in  1  downstream accepts
- o_SOF  out  1  delayed i_SOF
- o_EOL  out  1  delayed i_EOL
- o_PIXELS  out  P_CH_NUM*P_PIX_BIT  corrected pixels
- i_REG_ENA  in  1  correction enable
- i_REG_ARR_TYPE  in  2  Bayer phase XOR mask
- i_REG_GAIN_VEC  in  4*P_GAIN_BIT  gains indexed 0..3
- i_REG_PEDESTAL  in  P_PED_BIT  pedestal
- i_REG_THRES  in  P_PIX_BIT  bypass threshold
- i_REG_SFT  in  P_SFT_BIT  extra right shift

Behaviour:
- Reset:
  - All pipeline valids, o_VALID, o_SOF, o_EOL clear; o_PIXELS = 0.
  - Active (shadow) registers clear, so correction is disabled after reset; row parity = 0.
  - Reset mid-frame discards all in-flight beats; no output until a new beat is accepted.
- Handshake:
  - adv = !o_VALID || i_READY; o_READY = adv.
  - Input accepted when i_VALID && adv.
  - All three stages shift together on adv. Bubbles are carried, not collapsed.
  - Latency is 3 cycles from acceptance to o_VALID when not stalled.
  - o_* hold stable while o_VALID && !i_READY.
- Shadowing:
  - On an accepted beat with i_SOF = 1, all i_REG_* are latched into the active set.
  - That beat and every later beat use the new values.
  - i_REG_* changes at any other time have no effect.
- Bayer phase:
  - row toggles after each accepted beat with i_EOL = 1.
  - row is forced to 0 for an accepted i_SOF beat; the beat itself uses row 0.
  - Channel c has col = c[0].
  - Gain index = {row, col} XOR active ARR_TYPE.
  - With i_SOF and i_EOL on the same beat: the beat uses row 0, and row becomes 1 afterwards.
- Arithmetic, per channel:
  - Stage 1: d = pix - ped, signed, P_PIX_BIT+1 bits; bypass flag = !ENA || pix <= THRES.
  - Stage 2: p = d * gain, signed full width (no truncation).
  - Stage 3: r = ped + ((p + 2^(7+SFT)) >>> (8+SFT)), arithmetic shift with round-half-up; clamp r to [0, 2^P_PIX_BIT-1].
  - Bypass outputs pix unchanged.
- Sideband: SOF and EOL travel with their beat.

Decomposition:
- Package foo_corr_pkg holds:
  - the fractional-bit constant (8);
  - the gain-index typedef (2 bits);
  - a per-channel data struct carrying d, bypass and raw pix.
- Sub-module foo_corr_lane: one channel's 3-stage datapath with an enable input. The top instantiates P_CH_NUM lanes and owns the handshake, shadow registers and row counter.

Test Plan:
- Disabled path: reset, then an SOF beat with ENA = 0 and pixels {100, 200, 300, 4000} -> the same pixels out 3 cycles later, with o_SOF = 1.
- Gain, 12-bit: ENA = 1, ped = 64, gain0 = 512, SFT = 0, ARR = 0, THRES = 0; ch0 = 1064 -> 64 + 2000 = 2064. ch0 = 3000 -> clamps to 4095.
- Bayer selection: gains {256, 512, 768, 1024}, ped = 0, all pixels 100. Row 0 gives {100, 200, 100, 200}; after an EOL beat, row 1 gives {300, 400, 300, 400}. ARR = 3 swaps to {400, 300, 400, 300} from row 0.
- Threshold and pedestal: THRES = 500, ped = 64, gain 512; pix 500 -> 500 (bypass); pix 501 -> 938.
- Backpressure: hold i_READY = 0 for 5 cycles during a 10-beat burst -> no beat lost or duplicated, o_PIXELS stable while stalled, o_READY = 0 while o_VALID && !i_READY.
- Shadowing and reset: change gain mid-frame -> no effect until the next SOF beat. Assert i_RSTn low mid-burst -> o_VALID = 0 immediately and active ENA = 0.

Source files
------------

// File: rtl/foo_corr_pkg.sv
// Shared constants and types for the foo multi-channel pixel correction stage.
package foo_corr_pkg;

   localparam int CORR_FRAC_BIT    = 8;
   localparam int CORR_PIX_MAX_BIT = 16;

   typedef logic [1:0] gain_idx_t;

   // Stage-1 per-channel payload, sized for the widest supported pixel.
   typedef struct packed {
      logic signed [CORR_PIX_MAX_BIT:0] d;
      logic                             bypass;
      logic [CORR_PIX_MAX_BIT-1:0]      pix;
   } corr_chan_t;

   function automatic gain_idx_t gain_idx(input logic row, input logic col, input gain_idx_t arr);
      return gain_idx_t'({row, col}) ^ arr;
   endfunction

endpackage

// File: rtl/foo_corr_lane.sv
// One channel of the correction datapath: pedestal subtract, gain multiply,
// rounded shift, pedestal restore and clamp, advancing only when en is high.
module foo_corr_lane
   import foo_corr_pkg::*;
#(
   parameter int P_PIX_BIT  = 12,
   parameter int P_GAIN_BIT = 10,
   parameter int P_SFT_BIT  = 3,
   parameter int P_PED_BIT  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [P_PIX_BIT-1:0]  pix,
   input  logic                  ena,
   input  logic [P_PIX_BIT-1:0]  thres,
   input  logic [P_PED_BIT-1:0]  ped,
   input  logic [P_GAIN_BIT-1:0] gain,
   input  logic [P_SFT_BIT-1:0]  sft,
   output logic [P_PIX_BIT-1:0]  pix_out
);

   localparam int D_W    = CORR_PIX_MAX_BIT + 1;
   localparam int PROD_W = D_W + P_GAIN_BIT + 1;
   localparam int ACC_W  = PROD_W + 1;
   localparam int SUM_W  = ACC_W + 1;

   localparam logic [CORR_PIX_MAX_BIT-1:0] RAW_MAX = CORR_PIX_MAX_BIT'((1 << P_PIX_BIT) - 1);
   localparam logic signed [SUM_W-1:0]     PIX_MAX = SUM_W'((1 << P_PIX_BIT) - 1);

   // Round half up: add half an output LSB, then shift arithmetically.
   function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [PROD_W-1:0] p,
                                                            input logic [P_SFT_BIT-1:0]    s);
      logic signed [ACC_W-1:0] half;
      logic signed [ACC_W-1:0] acc;
      half = ACC_W'(1) << (CORR_FRAC_BIT - 1 + int'(s));
      acc  = ACC_W'(p) + half;
      return acc >>> (CORR_FRAC_BIT + int'(s));
   endfunction

   function automatic logic [P_PIX_BIT-1:0] clamp_pix(input logic signed [SUM_W-1:0] r);
      logic [P_PIX_BIT-1:0] res;
      if (r[SUM_W-1])
         res = '0;
      else if (r > PIX_MAX)
         res = '1;
      else
         res = r[P_PIX_BIT-1:0];
      return res;
   endfunction

   function automatic logic [P_PIX_BIT-1:0] sat_pix(input logic [CORR_PIX_MAX_BIT-1:0] v);
      logic [P_PIX_BIT-1:0] res;
      if (v > RAW_MAX)
         res = '1;
      else
         res = v[P_PIX_BIT-1:0];
      return res;
   endfunction

   logic [P_PIX_BIT-1:0]     ped_pix;
   logic signed [P_PIX_BIT:0] d_w;
   corr_chan_t               chan_w;

   assign ped_pix = P_PIX_BIT'(ped);
   assign d_w     = $signed({1'b0, pix}) - $signed({1'b0, ped_pix});

   always_comb begin
      chan_w        = '0;
      chan_w.d      = D_W'(d_w);
      chan_w.bypass = !ena || (pix <= thres);
      chan_w.pix    = CORR_PIX_MAX_BIT'(pix);
   end

   corr_chan_t               chan_p0;
   logic [P_GAIN_BIT-1:0]    gain_p0;
   logic [P_PED_BIT-1:0]     ped_p0;
   logic [P_SFT_BIT-1:0]     sft_p0;
   logic signed [PROD_W-1:0] prod_p1;
   logic                     bypass_p1;
   logic [P_PIX_BIT-1:0]     pix_p1;
   logic [P_PED_BIT-1:0]     ped_p1;
   logic [P_SFT_BIT-1:0]     sft_p1;
   logic [P_PIX_BIT-1:0]     pix_p2;
   logic signed [SUM_W-1:0]  sum_w;

   always_ff @(posedge clk) begin
      if (en) begin
         // p0: pedestal-referenced difference and bypass decision
         chan_p0   <= chan_w;
         gain_p0   <= gain;
         ped_p0    <= ped;
         sft_p0    <= sft;
         // p1: full-width signed product
         prod_p1   <= PROD_W'($signed(chan_p0.d)) * PROD_W'($signed({1'b0, gain_p0}));
         bypass_p1 <= chan_p0.bypass;
         pix_p1    <= sat_pix(chan_p0.pix);
         ped_p1    <= ped_p0;
         sft_p1    <= sft_p0;
      end
   end

   assign sum_w = SUM_W'(round_shift(prod_p1, sft_p1)) + $signed(SUM_W'(ped_p1));

   // p2: registered output, cleared by reset so o_PIXELS starts at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pix_p2 <= '0;
      else if (en)
         pix_p2 <= bypass_p1 ? pix_p1 : clamp_pix(sum_w);
   end

   assign pix_out = pix_p2;

endmodule

// File: rtl/foo_correction_mc.sv
// Multi-channel Bayer pixel correction: shadowed configuration, row-phase
// tracking and a 3-stage valid/ready pipeline around P_CH_NUM lanes.
module foo_correction_mc
   import foo_corr_pkg::*;
#(
   parameter int P_CH_NUM   = 4,
   parameter int P_PIX_BIT  = 12,
   parameter int P_GAIN_BIT = 10,
   parameter int P_SFT_BIT  = 3,
   parameter int P_PED_BIT  = 10
) (
   input  logic                          i_CLK,
   input  logic                          i_RSTn,
   input  logic                          i_VALID,
   output logic                          o_READY,
   input  logic                          i_SOF,
   input  logic                          i_EOL,
   input  logic [P_CH_NUM*P_PIX_BIT-1:0] i_PIXELS,
   output logic                          o_VALID,
   input  logic                          i_READY,
   output logic                          o_SOF,
   output logic                          o_EOL,
   output logic [P_CH_NUM*P_PIX_BIT-1:0] o_PIXELS,
   input  logic                          i_REG_ENA,
   input  logic [1:0]                    i_REG_ARR_TYPE,
   input  logic [4*P_GAIN_BIT-1:0]       i_REG_GAIN_VEC,
   input  logic [P_PED_BIT-1:0]          i_REG_PEDESTAL,
   input  logic [P_PIX_BIT-1:0]          i_REG_THRES,
   input  logic [P_SFT_BIT-1:0]          i_REG_SFT
);

   logic adv;
   logic acc;
   logic vld_p0, vld_p1, vld_p2;
   logic sof_p0, sof_p1, sof_p2;
   logic eol_p0, eol_p1, eol_p2;

   logic                    act_ena;
   gain_idx_t               act_arr;
   logic [4*P_GAIN_BIT-1:0] act_gain_vec;
   logic [P_PED_BIT-1:0]    act_ped;
   logic [P_PIX_BIT-1:0]    act_thres;
   logic [P_SFT_BIT-1:0]    act_sft;
   logic                    row;

   assign adv     = !vld_p2 || i_READY;
   assign o_READY = adv;
   assign acc     = i_VALID && adv;

   // An SOF beat already runs with the settings it loads into the shadow set.
   logic                    cur_ena;
   gain_idx_t               cur_arr;
   logic [4*P_GAIN_BIT-1:0] cur_gain_vec;
   logic [P_PED_BIT-1:0]    cur_ped;
   logic [P_PIX_BIT-1:0]    cur_thres;
   logic [P_SFT_BIT-1:0]    cur_sft;
   logic                    cur_row;

   assign cur_ena      = i_SOF ? i_REG_ENA      : act_ena;
   assign cur_arr      = i_SOF ? i_REG_ARR_TYPE : act_arr;
   assign cur_gain_vec = i_SOF ? i_REG_GAIN_VEC : act_gain_vec;
   assign cur_ped      = i_SOF ? i_REG_PEDESTAL : act_ped;
   assign cur_thres    = i_SOF ? i_REG_THRES    : act_thres;
   assign cur_sft      = i_SOF ? i_REG_SFT      : act_sft;
   assign cur_row      = i_SOF ? 1'b0           : row;

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         act_ena      <= 1'b0;
         act_arr      <= '0;
         act_gain_vec <= '0;
         act_ped      <= '0;
         act_thres    <= '0;
         act_sft      <= '0;
         row          <= 1'b0;
      end else if (acc) begin
         if (i_SOF) begin
            act_ena      <= i_REG_ENA;
            act_arr      <= i_REG_ARR_TYPE;
            act_gain_vec <= i_REG_GAIN_VEC;
            act_ped      <= i_REG_PEDESTAL;
            act_thres    <= i_REG_THRES;
            act_sft      <= i_REG_SFT;
         end
         row <= i_EOL ? !cur_row : cur_row;
      end
   end

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         vld_p0 <= 1'b0; vld_p1 <= 1'b0; vld_p2 <= 1'b0;
         sof_p0 <= 1'b0; sof_p1 <= 1'b0; sof_p2 <= 1'b0;
         eol_p0 <= 1'b0; eol_p1 <= 1'b0; eol_p2 <= 1'b0;
      end else if (adv) begin
         // p0 -> p1 -> p2: bubbles move with the data
         vld_p0 <= i_VALID;
         sof_p0 <= i_VALID && i_SOF;
         eol_p0 <= i_VALID && i_EOL;
         vld_p1 <= vld_p0;
         sof_p1 <= sof_p0;
         eol_p1 <= eol_p0;
         vld_p2 <= vld_p1;
         sof_p2 <= sof_p1;
         eol_p2 <= eol_p1;
      end
   end

   assign o_VALID = vld_p2;
   assign o_SOF   = sof_p2;
   assign o_EOL   = eol_p2;

   for (genvar c = 0; c < P_CH_NUM; c++) begin : g_lane
      gain_idx_t             idx;
      logic [P_GAIN_BIT-1:0] lane_gain;

      assign idx       = gain_idx(cur_row, 1'(c % 2), cur_arr);
      assign lane_gain = cur_gain_vec[int'(idx)*P_GAIN_BIT +: P_GAIN_BIT];

      foo_corr_lane #(
         .P_PIX_BIT  (P_PIX_BIT),
         .P_GAIN_BIT (P_GAIN_BIT),
         .P_SFT_BIT  (P_SFT_BIT),
         .P_PED_BIT  (P_PED_BIT)
      ) u_lane (
         .clk     (i_CLK),
         .rst_n   (i_RSTn),
         .en      (adv),
         .pix     (i_PIXELS[c*P_PIX_BIT +: P_PIX_BIT]),
         .ena     (cur_ena),
         .thres   (cur_thres),
         .ped     (cur_ped),
         .gain    (lane_gain),
         .sft     (cur_sft),
         .pix_out (o_PIXELS[c*P_PIX_BIT +: P_PIX_BIT])
      );
   end

endmodule
